// File: rtl/jam_cost_sched_pkg.sv
// Shared types and constants for the job-assignment cost scheduler.
package jam_pkg;

   localparam int WJ_W      = 3;
   localparam int COST_IN_W = 7;

   // Wide enough for any COST_W up to 32; users take the low COST_W bits.
   localparam logic [31:0] COST_INIT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      START   = 2'd0,
      COLLECT = 2'd1,
      EMIT    = 2'd2,
      HALT    = 2'd3
   } state_e;

endpackage

// File: rtl/jam_cost_sched_if.sv
// Engine-side cost-read bus: request/address towards the scheduler, grant/response back.
interface jam_cost_sched_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]                  req;
   logic [jam_pkg::WJ_W*NREQ-1:0]    req_w;
   logic [jam_pkg::WJ_W*NREQ-1:0]    req_j;
   logic [NREQ-1:0]                  gnt;
   logic [NREQ-1:0]                  rsp_valid;
   logic [jam_pkg::COST_IN_W-1:0]    rsp_cost;

   modport master (
      output req, req_w, req_j,
      input  gnt, rsp_valid, rsp_cost
   );

   modport slave (
      input  req, req_w, req_j,
      output gnt, rsp_valid, rsp_cost
   );
endinterface

// File: rtl/jam_cost_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr+1, wrapping.
module rr_arbiter #(
   parameter int NREQ  = 2,
   parameter int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt
);

   logic [PTR_W:0] cand_s;
   logic           found_s;

   // Scan candidates in priority order starting just after the last winner.
   always_comb begin
      gnt     = {NREQ{1'b0}};
      found_s = 1'b0;
      cand_s  = {(PTR_W+1){1'b0}};
      for (int k = 1; k <= NREQ; k++) begin
         cand_s = {1'b0, ptr} + (PTR_W+1)'(k);
         if (cand_s >= (PTR_W+1)'(NREQ)) begin
            cand_s = cand_s - (PTR_W+1)'(NREQ);
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && req[cand_s[PTR_W-1:0]]) begin
            gnt[cand_s[PTR_W-1:0]] = 1'b1;
            found_s                = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/jam_cost_sched.sv
// Shares the cost-table port between NREQ search engines and merges their results
// into a single minimum-cost / match-count report.
module jam_cost_sched
   import jam_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int CNT_W  = 4,
   parameter int COST_W = 10
) (
   input  logic                    CLK,
   input  logic                    RST,
   output logic                    start,
   jam_cost_sched_if.slave         bus,
   output logic [WJ_W-1:0]         W,
   output logic [WJ_W-1:0]         J,
   input  logic [COST_IN_W-1:0]    Cost,
   input  logic [NREQ-1:0]         done,
   input  logic [COST_W*NREQ-1:0]  res_min,
   input  logic [CNT_W*NREQ-1:0]   res_cnt,
   output logic [COST_W-1:0]       MinCost,
   output logic [CNT_W-1:0]        MatchCount,
   output logic                    Valid
);

   localparam int                PTR_W     = $clog2(NREQ);
   localparam logic [COST_W-1:0] COST_ONES = COST_INIT[COST_W-1:0];

   state_e            state_r;
   logic [PTR_W-1:0]  ptr_r;
   logic [NREQ-1:0]   flag_r;
   logic              arb_en_s;
   logic [NREQ-1:0]   arb_req_s;
   logic [NREQ-1:0]   gnt_s;
   logic [PTR_W-1:0]  gnt_idx_s;
   logic [WJ_W-1:0]   sel_w_s;
   logic [WJ_W-1:0]   sel_j_s;
   logic [COST_W-1:0] min_s;
   logic [CNT_W-1:0]  cnt_s;
   logic [NREQ-1:0]   flag_s;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
      logic [CNT_W:0] sum_v;
      sum_v = {1'b0, a} + {1'b0, b};
      if (sum_v[CNT_W]) begin
         return {CNT_W{1'b1}};
      end else begin
         return sum_v[CNT_W-1:0];
      end
   endfunction

   assign arb_en_s  = (state_r == COLLECT) || (state_r == EMIT);
   assign arb_req_s = arb_en_s ? bus.req : {NREQ{1'b0}};
   assign bus.gnt      = gnt_s;
   assign bus.rsp_cost = Cost;

   rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
      .req (arb_req_s),
      .ptr (ptr_r),
      .gnt (gnt_s)
   );

   // Decode the one-hot grant into an index and pick that engine's address.
   always_comb begin
      gnt_idx_s = {PTR_W{1'b0}};
      sel_w_s   = {WJ_W{1'b0}};
      sel_j_s   = {WJ_W{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_s[i]) begin
            gnt_idx_s = PTR_W'(i);
            sel_w_s   = bus.req_w[i*WJ_W +: WJ_W];
            sel_j_s   = bus.req_j[i*WJ_W +: WJ_W];
         end else begin
            gnt_idx_s = gnt_idx_s;
         end
      end
   end

   // Fold every fresh done in index order; later engines see earlier folds.
   always_comb begin
      min_s  = MinCost;
      cnt_s  = MatchCount;
      flag_s = flag_r;
      for (int i = 0; i < NREQ; i++) begin
         if ((state_r == COLLECT) && done[i] && !flag_r[i]) begin
            flag_s[i] = 1'b1;
            if (res_min[i*COST_W +: COST_W] < min_s) begin
               min_s = res_min[i*COST_W +: COST_W];
               cnt_s = res_cnt[i*CNT_W +: CNT_W];
            end else if (res_min[i*COST_W +: COST_W] == min_s) begin
               cnt_s = sat_add(cnt_s, res_cnt[i*CNT_W +: CNT_W]);
            end else begin
               cnt_s = cnt_s;
            end
         end else begin
            flag_s[i] = flag_s[i];
         end
      end
   end

   // Arbitration registers, control FSM and merged result.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r       <= START;
         ptr_r         <= PTR_W'(NREQ - 1);
         flag_r        <= {NREQ{1'b0}};
         W             <= {WJ_W{1'b0}};
         J             <= {WJ_W{1'b0}};
         bus.rsp_valid <= {NREQ{1'b0}};
         start         <= 1'b0;
         Valid         <= 1'b0;
         MinCost       <= COST_ONES;
         MatchCount    <= {CNT_W{1'b0}};
      end else begin
         bus.rsp_valid <= gnt_s;
         if (|gnt_s) begin
            W     <= sel_w_s;
            J     <= sel_j_s;
            ptr_r <= gnt_idx_s;
         end
         case (state_r)
            START: begin
               start   <= 1'b1;
               Valid   <= 1'b0;
               state_r <= COLLECT;
            end
            COLLECT: begin
               start      <= 1'b0;
               flag_r     <= flag_s;
               MinCost    <= min_s;
               MatchCount <= cnt_s;
               if (&flag_s) begin
                  Valid   <= 1'b1;
                  state_r <= EMIT;
               end
            end
            EMIT: begin
               start   <= 1'b0;
               Valid   <= 1'b0;
               state_r <= HALT;
            end
            HALT: begin
               start   <= 1'b0;
               Valid   <= 1'b0;
            end
            default: begin
               start   <= 1'b0;
               Valid   <= 1'b0;
               state_r <= START;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jam_cost_sched.sv
// Self-checking bench for jam_cost_sched: table-driven arbitration vectors, randomized
// traffic against a behavioural model, and directed/random merge and reset sequences.
module tb_jam_cost_sched;
   import jam_pkg::*;

   localparam int NREQ   = 2;
   localparam int CNT_W  = 4;
   localparam int COST_W = 10;

   logic                   CLK = 1'b0;
   logic                   RST;
   logic                   start;
   logic [2:0]             W, J;
   logic [6:0]             Cost;
   logic [NREQ-1:0]        done;
   logic [COST_W*NREQ-1:0] res_min;
   logic [CNT_W*NREQ-1:0]  res_cnt;
   logic [COST_W-1:0]      MinCost;
   logic [CNT_W-1:0]       MatchCount;
   logic                   Valid;

   logic [6:0] cost_tab [0:63];

   jam_cost_sched_if #(.NREQ(NREQ)) bus();

   jam_cost_sched #(.NREQ(NREQ), .CNT_W(CNT_W), .COST_W(COST_W)) dut (
      .CLK(CLK), .RST(RST), .start(start), .bus(bus), .W(W), .J(J), .Cost(Cost),
      .done(done), .res_min(res_min), .res_cnt(res_cnt),
      .MinCost(MinCost), .MatchCount(MatchCount), .Valid(Valid)
   );

   always #5 CLK = ~CLK;
   assign Cost = cost_tab[{W, J}];

   int         n_vec = 0;
   int         n_bad = 0;
   int         m_ptr;
   logic [1:0] e_rv;
   logic [2:0] e_w, e_j;

   typedef struct {
      logic [1:0] req;
      logic [2:0] w0, j0, w1, j1;
      logic [1:0] gnt;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Round-robin reference: first requester strictly after the last winner, wrapping.
   function automatic logic [1:0] model_gnt(input logic [1:0] r, input int p);
      for (int k = 1; k <= NREQ; k++) begin
         int i;
         i = (p + k) % NREQ;
         if (r[i]) return 2'(1 << i);
      end
      return 2'b00;
   endfunction

   task automatic do_reset();
      RST = 1'b1; bus.req = 2'b00; done = 2'b00;
      tick();
      chk("rst W", 32'(W), 32'd0);
      chk("rst J", 32'(J), 32'd0);
      chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst Valid", 32'(Valid), 32'd0);
      chk("rst start", 32'(start), 32'd0);
      chk("rst MinCost", 32'(MinCost), 32'd1023);
      chk("rst MatchCount", 32'(MatchCount), 32'd0);
      m_ptr = NREQ - 1; e_rv = 2'b00; e_w = 3'd0; e_j = 3'd0;
      RST = 1'b0;
      bus.req = 2'b11;
      #1;
      chk("start_state gnt gated", 32'(bus.gnt), 32'd0);
      bus.req = 2'b00;
      tick();
      chk("start pulse cyc1", 32'(start), 32'd1);
      tick();
      chk("start low cyc2", 32'(start), 32'd0);
   endtask

   task automatic bus_cycle(input logic [1:0] r, input logic [2:0] w0, input logic [2:0] j0,
                            input logic [2:0] w1, input logic [2:0] j1,
                            input logic [1:0] exp_g, input string tag);
      chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(e_rv));
      chk({tag, " W"}, 32'(W), 32'(e_w));
      chk({tag, " J"}, 32'(J), 32'(e_j));
      if (e_rv != 2'b00) chk({tag, " rsp_cost"}, 32'(bus.rsp_cost), 32'(cost_tab[{e_w, e_j}]));
      bus.req   = r;
      bus.req_w = {w1, w0};
      bus.req_j = {j1, j0};
      #1;
      chk({tag, " gnt"}, 32'(bus.gnt), 32'(exp_g));
      e_rv = exp_g;
      if (exp_g[0]) begin
         e_w = w0; e_j = j0; m_ptr = 0;
      end else if (exp_g[1]) begin
         e_w = w1; e_j = j1; m_ptr = 1;
      end
      tick();
   endtask

   task automatic run_merge(input logic [9:0] m0, input logic [9:0] m1,
                            input logic [3:0] c0, input logic [3:0] c1,
                            input int t0, input int t1, input int d0, input int d1,
                            input string tag);
      int         last;
      int         ec;
      logic [9:0] em;
      last = (t0 > t1) ? t0 : t1;
      em = 10'h3FF;
      if (m0 < em) em = m0;
      if (m1 < em) em = m1;
      ec = 0;
      if (m0 == em) ec += int'(c0);
      if (m1 == em) ec += int'(c1);
      if (ec > 15) ec = 15;
      for (int cyc = 0; cyc <= last + 3; cyc++) begin
         chk({tag, " Valid"}, 32'(Valid), 32'(cyc == last + 1));
         if (cyc == 0) begin
            chk({tag, " MinCost init"}, 32'(MinCost), 32'd1023);
            chk({tag, " MatchCount init"}, 32'(MatchCount), 32'd0);
         end else if (cyc > last) begin
            chk({tag, " MinCost"}, 32'(MinCost), 32'(em));
            chk({tag, " MatchCount"}, 32'(MatchCount), 32'(ec));
         end
         done[0] = (cyc == t0) || (d0 > 0 && cyc == t0 + d0);
         done[1] = (cyc == t1) || (d1 > 0 && cyc == t1 + d1);
         res_min[9:0]   = (cyc == t0) ? m0 : 10'($urandom_range(0, 20));
         res_min[19:10] = (cyc == t1) ? m1 : 10'($urandom_range(0, 20));
         res_cnt[3:0]   = (cyc == t0) ? c0 : 4'($urandom_range(0, 15));
         res_cnt[7:4]   = (cyc == t1) ? c1 : 4'($urandom_range(0, 15));
         tick();
      end
      done = 2'b00;
   endtask

   initial begin
      logic [1:0] pend;
      logic [2:0] aw [2];
      logic [2:0] aj [2];
      logic [1:0] g;
      logic [9:0] pick [4];

      for (int i = 0; i < 64; i++) cost_tab[i] = 7'($urandom_range(0, 127));
      cost_tab[29] = 7'd42;
      RST = 1'b1; bus.req = 2'b00; bus.req_w = 6'd0; bus.req_j = 6'd0;
      done = 2'b00; res_min = 20'd0; res_cnt = 8'd0;

      tbl[0] = '{2'b01, 3'd3, 3'd5, 3'd0, 3'd0, 2'b01};
      tbl[1] = '{2'b11, 3'd1, 3'd2, 3'd4, 3'd6, 2'b10};
      tbl[2] = '{2'b11, 3'd1, 3'd2, 3'd0, 3'd0, 2'b01};
      tbl[3] = '{2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00};
      tbl[4] = '{2'b10, 3'd0, 3'd0, 3'd7, 3'd7, 2'b10};
      tbl[5] = '{2'b10, 3'd0, 3'd0, 3'd0, 3'd1, 2'b10};
      tbl[6] = '{2'b01, 3'd2, 3'd2, 3'd0, 3'd0, 2'b01};
      tbl[7] = '{2'b11, 3'd6, 3'd1, 3'd5, 3'd3, 2'b10};
      tbl[8] = '{2'b11, 3'd6, 3'd1, 3'd5, 3'd3, 2'b01};
      tbl[9] = '{2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00};

      do_reset();
      for (int v = 0; v < 10; v++)
         bus_cycle(tbl[v].req, tbl[v].w0, tbl[v].j0, tbl[v].w1, tbl[v].j1, tbl[v].gnt, "tbl");

      // Continuous requests from both engines must alternate with no idle cycle.
      for (int k = 0; k < 6; k++)
         bus_cycle(2'b11, 3'(k), 3'd4, 3'd6, 3'(k), ((k % 2) == 0) ? 2'b10 : 2'b01, "fair");

      pend = 2'b00;
      aw[0] = 3'd0; aj[0] = 3'd0; aw[1] = 3'd0; aj[1] = 3'd0;
      for (int n = 0; n < 300; n++) begin
         for (int e = 0; e < 2; e++) begin
            if (!pend[e]) begin
               pend[e] = 1'($urandom_range(0, 1));
               aw[e]   = 3'($urandom_range(0, 7));
               aj[e]   = 3'($urandom_range(0, 7));
            end
         end
         g = model_gnt(pend, m_ptr);
         bus_cycle(pend, aw[0], aj[0], aw[1], aj[1], g, "rnd");
         pend = pend & ~g;
      end
      bus_cycle(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00, "rnd_tail");

      do_reset();
      run_merge(10'd100, 10'd90, 4'd2, 4'd3, 1, 3, 0, 0, "merge_seq");
      do_reset();
      run_merge(10'd90, 10'd90, 4'd9, 4'd9, 1, 1, 2, 0, "merge_sat");
      do_reset();
      run_merge(10'd50, 10'd50, 4'd1, 4'd2, 1, 4, 1, 0, "merge_dup");
      do_reset();
      run_merge(10'd1023, 10'd1023, 4'd4, 4'd5, 0, 0, 0, 0, "merge_init_tie");

      pick[0] = 10'd100; pick[1] = 10'd200; pick[2] = 10'd1023; pick[3] = 10'd150;
      for (int it = 0; it < 8; it++) begin
         do_reset();
         run_merge(pick[$urandom_range(0, 3)], pick[$urandom_range(0, 3)],
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 3), $urandom_range(0, 3), "merge_rnd");
      end

      // Reset in the middle of a read with one result already folded.
      do_reset();
      done = 2'b01; res_min[9:0] = 10'd77; res_cnt[3:0] = 4'd1;
      tick();
      done = 2'b00;
      chk("mid MinCost", 32'(MinCost), 32'd77);
      chk("mid MatchCount", 32'(MatchCount), 32'd1);
      bus_cycle(2'b01, 3'd3, 3'd5, 3'd0, 3'd0, 2'b01, "mid");
      chk("mid rsp_valid", 32'(bus.rsp_valid), 32'd1);
      RST = 1'b1;
      #1;
      chk("async rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("async W", 32'(W), 32'd0);
      chk("async MinCost", 32'(MinCost), 32'd1023);
      chk("async MatchCount", 32'(MatchCount), 32'd0);
      chk("async gnt", 32'(bus.gnt), 32'd0);
      do_reset();
      bus_cycle(2'b11, 3'd2, 3'd3, 3'd4, 3'd5, 2'b01, "ptr_rst");
      bus_cycle(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00, "ptr_rst");
      run_merge(10'd300, 10'd200, 4'd5, 4'd6, 3, 1, 0, 0, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/jam_cost_sched.md
Name: jam_cost_sched

Overview:
- Shares the single external cost-table port (W, J -> Cost) between NREQ parallel permutation-search engines using round-robin arbitration.
- Routes each Cost response back to the engine that was granted.
- Starts all engines once after reset, collects their partial results and merges them into one MinCost/MatchCount/Valid report.
- Sits between the search engines and the cost-table interface at the top level of the job-assignment design.

Parameters:
- NREQ, 2, number of search engines (2..4)
- CNT_W, 4, width of match-count fields
- COST_W, 10, width of accumulated-cost fields

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- start  out  1  one-cycle start pulse to all engines
- req  in  NREQ  per-engine cost-read request
- req_w  in  3*NREQ  worker index, engine i at bits [3i+2:3i]
- req_j  in  3*NREQ  job index, same packing
- gnt  out  NREQ  one-hot grant, combinational from req and the priority pointer
- rsp_valid  out  NREQ  one-hot; Cost is valid for this engine this cycle
- rsp_cost  out  7  equals Cost (combinational pass-through)
- W  out  3  registered worker address to the cost table
- J  out  3  registered job address to the cost table
- Cost  in  7  cost-table data; valid in the cycle W/J are presented
- done  in  NREQ  per-engine one-cycle completion pulse
- res_min  in  COST_W*NREQ  per-engine minimum cost, sampled on done
- res_cnt  in  CNT_W*NREQ  per-engine match count, sampled on done
- MinCost  out  COST_W  merged minimum
- MatchCount  out  CNT_W  merged count
- Valid  out  1  one-cycle pulse; merged result is final

Behaviour:
- Reset: RST is asynchronous, active-high; the clock is CLK.
- Reset values:
  - W=0, J=0, rsp_valid=0, Valid=0, start=0
  - MinCost = all ones, MatchCount=0
  - priority pointer = NREQ-1, so engine 0 has highest priority first
  - state=START, done flags cleared
- Arbitration:
  - Each cycle, grant at most one requester: the first asserted req at or after (ptr+1) mod NREQ, wrapping.
  - No req means gnt=0 and ptr unchanged.
  - On gnt[i] at edge: W/J <= req_w/req_j of engine i, rsp_valid <= one-hot i, ptr <= i.
  - No grant means rsp_valid <= 0; W/J hold.
- Handshake:
  - A requester holds req and its address stable until it sees gnt.
  - It may re-request in the very next cycle, so back-to-back grants are allowed and yield one grant per cycle.
  - Response latency is exactly 1 cycle after gnt.
  - rsp_cost = Cost during the cycle rsp_valid is high.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,...,NREQ-1,0...
- Gating: req is ignored (gnt=0) in states START and HALT.
- State machine:
  - START: start=1 for this one cycle, then go to COLLECT.
  - COLLECT: on each cycle, for each done[i] with its flag clear, set the flag and fold engine i's result into the merge.
    - Simultaneous done pulses are all folded in the same cycle, in index order.
    - A done[i] whose flag is already set is ignored.
    - When all flags are set (including those set this cycle), go to EMIT.
  - EMIT: Valid=1 for one cycle, then go to HALT.
  - HALT: outputs hold; leave only via RST.
- Merge rule, applied per folded engine:
  - res_min < MinCost: MinCost <= res_min, MatchCount <= res_cnt.
  - res_min == MinCost: MatchCount <= MatchCount + res_cnt, saturating at 2^CNT_W-1.
  - Otherwise: no change.
  - Within one cycle, later indices see the result of earlier indices' folds (combinational chain).
- Reset mid-operation: all state, flags and pointer return to reset values; the in-flight response is dropped (rsp_valid=0).

Decomposition:
- Package jam_pkg:
  - WJ_W=3, COST_IN_W=7
  - state enum {START, COLLECT, EMIT, HALT}
  - COST_INIT = all ones
- Sub-module rr_arbiter: NREQ-wide round-robin arbiter with req, ptr in, one-hot gnt out. Purely combinational; ptr is held in the parent.
- The merge chain stays in the parent.

Test Plan:
- Reset, then run: start pulses only in cycle 1 after RST falls; MinCost=1023, MatchCount=0, Valid=0 before any done.
- Single request: req[0]=1 with W=3, J=5, table cost 42 -> gnt=01 the same cycle; next cycle W=3, J=5, rsp_valid=01, rsp_cost=42.
- Both engines request continuously: grants alternate 0,1,0,1; no idle cycles; each rsp_valid follows its gnt by 1 cycle with the correct Cost.
- Done at different cycles with mins 100 then 90, counts 2 and 3 -> MinCost=90, MatchCount=3, Valid pulses once, one cycle after the second done.
- Simultaneous done, mins 90/90, counts 9/9 with CNT_W=4 -> MatchCount saturates at 15, MinCost=90; a repeated done[0] afterwards changes nothing.
- Assert RST during a granted read and in COLLECT with one flag set -> all outputs return to reset values; rsp_valid=0 next cycle; a fresh start pulse follows reset release.
